if_inst_queue: RTL

IF_INST_QUEUE -- requirements
Module: if_inst_queue

---
 rtl/cpu_defs.sv | 20 ++
 rtl/inst_fifo.sv | 68 ++++++
 rtl/if_inst_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU type definitions.
// Word-level types used across the front end, the architectural reset
// vector, and the entry format of the fetch-to-decode instruction queue.
package cpu_defs;

  typedef logic [31:0] Inst_t;      // raw instruction word
  typedef logic [31:0] VirtAddr_t;  // virtual address
  typedef logic        Bit_t;       // single flag

  localparam VirtAddr_t RESET_PC_DEFAULT = 32'hbfc00000;

  // One queued instruction. err marks a misaligned-fetch fault entry,
  // in which case inst is forced to zero.
  typedef struct packed {
    Inst_t     inst;
    VirtAddr_t pc;
    Bit_t      err;
  } inst_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Circular FIFO holding fetched instruction entries.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : empties the queue; overrides push and pop in that cycle
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head_data  : entry at the head (undefined when count == 0)
//   count      : number of valid entries, 0..DEPTH
module inst_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !clear;
  assign do_pop    = pop && !clear && (count != '0);
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The fetch side reserves a slot before requesting, so a push into a
  // full queue means the reservation logic is broken.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(do_push && count == FULL_COUNT)
  );

endmodule

// File: rtl/if_inst_queue.sv
// Instruction fetch unit with a decoupling instruction queue.
// Issues one word fetch at a time on a simple req/ready, rvalid bus and
// buffers returned words for decode. A flush redirects fetch and throws
// away both queued and in-flight instructions; a misaligned redirect
// target produces a single fault entry and stops fetching until the next
// flush.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : redirect, flush_pc is the new fetch address
//   ibus_req      : fetch request valid, ibus_addr its word address
//   ibus_ready    : bus accepts the request this cycle
//   ibus_rvalid   : returned word on ibus_rdata (one per accepted request)
//   inst_valid    : head entry presented to decode (inst, inst_pc,
//                   inst_addr_err); all zero when the queue is empty
//   inst_ready    : decode consumes the head entry
module if_inst_queue
  import cpu_defs::*;
#(
  parameter int        DEPTH    = 4,
  parameter VirtAddr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  VirtAddr_t flush_pc,
  output logic      ibus_req,
  output VirtAddr_t ibus_addr,
  input  logic      ibus_ready,
  input  logic      ibus_rvalid,
  input  Inst_t     ibus_rdata,
  output logic      inst_valid,
  output Inst_t     inst,
  output VirtAddr_t inst_pc,
  output logic      inst_addr_err,
  input  logic      inst_ready
);

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam int            ENTRY_W    = $bits(inst_entry_t);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // ST_WAIT and ST_DISCARD are exactly the states with one request
  // outstanding, so no separate outstanding counter is kept.
  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DISCARD,
    ST_HALT
  } state_t;

  state_t       state;
  VirtAddr_t    fetch_pc;
  logic [CW-1:0] count;
  logic         aligned;
  logic         has_space;
  logic         accept;
  logic         push;
  logic         pop;
  inst_entry_t  push_entry;
  inst_entry_t  head;
  logic [ENTRY_W-1:0] push_bits;
  logic [ENTRY_W-1:0] head_bits;

  assign aligned   = (fetch_pc[1:0] == 2'b00);
  assign has_space = (count < FULL_COUNT);

  // In FETCH nothing is outstanding, so count < DEPTH is the full
  // slot-reservation test. Flush withdraws an unaccepted request at once.
  assign ibus_req  = !rst && !flush && (state == ST_FETCH) && aligned && has_space;
  assign ibus_addr = fetch_pc;
  assign accept    = ibus_req && ibus_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value held over and no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (!flush) begin
      if (state == ST_WAIT && ibus_rvalid) begin
        // fetch_pc already advanced on acceptance; the word belongs to pc-4.
        push            = 1'b1;
        push_entry.inst = ibus_rdata;
        push_entry.pc   = fetch_pc - 32'd4;
        push_entry.err  = 1'b0;
      end else if (state == ST_FETCH && !aligned && has_space) begin
        push            = 1'b1;
        push_entry.inst = '0;
        push_entry.pc   = fetch_pc;
        push_entry.err  = 1'b1;
      end
    end
  end

  assign pop       = inst_valid && inst_ready;
  assign push_bits = push_entry;

  inst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_bits),
    .pop       (pop),
    .head_data (head_bits),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      if (flush) fetch_pc <= flush_pc;
      case (state)
        ST_FETCH: begin
          if (!flush) begin
            if (accept) begin
              state    <= ST_WAIT;
              fetch_pc <= fetch_pc + 32'd4;
            end else if (push) begin
              state <= ST_HALT;
            end
          end
        end
        // A response retires the outstanding request whether it is pushed
        // or dropped by a coincident flush; a flush alone leaves it pending.
        ST_WAIT: begin
          if (ibus_rvalid)  state <= ST_FETCH;
          else if (flush)   state <= ST_DISCARD;
        end
        ST_DISCARD: begin
          if (ibus_rvalid)  state <= ST_FETCH;
        end
        ST_HALT: begin
          if (flush)        state <= ST_FETCH;
        end
        default:            state <= ST_FETCH;
      endcase
    end
  end

  assign head          = inst_entry_t'(head_bits);
  assign inst_valid    = (count != '0);
  assign inst          = inst_valid ? head.inst : '0;
  assign inst_pc       = inst_valid ? head.pc   : '0;
  assign inst_addr_err = inst_valid && head.err;

endmodule
